pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_duty_div.sv | 96 +++++++++
 rtl/pwm_capture.sv | 181 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM blocks: default counter width, duty width
// and the FSM state encodings for the capture block and its duty divider.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DUTY_W    = 8;

  typedef enum logic [0:0] {
    ACQUIRE,
    MEASURE
  } cap_state_t;

  typedef enum logic [0:0] {
    DIV_IDLE,
    DIVIDE
  } div_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing floor(dividend / divisor) for a dividend of
// the form high << DUTY_W with high <= divisor, so the quotient never exceeds
// 2^DUTY_W and DUTY_W+1 quotient bits (one per cycle) are enough.
// start is accepted only while idle; done pulses for one cycle with the
// final quotient, which then holds until the next start.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W+DUTY_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic [DUTY_W:0]         quotient
);

  localparam int STEPS  = DUTY_W + 1;
  localparam int STEP_W = $clog2(STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  div_state_t          state, state_nxt;
  logic                load, iterate, last;
  logic [STEP_W-1:0]   step;
  logic [CNT_W:0]      rem;
  logic [CNT_W:0]      shifted;
  logic [DUTY_W-1:0]   low;
  logic [CNT_W-1:0]    dvs;
  logic                fits;

  // The first step compares the upper dividend part as-is; later steps
  // shift in the (zero) low dividend bits one at a time.
  assign shifted = (step == '0) ? rem : {rem[CNT_W-1:0], low[DUTY_W-1]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign busy    = (state == DIVIDE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and step control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    iterate   = 1'b0;
    last      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        iterate = 1'b1;
        if (step == LAST_STEP) begin
          last      = 1'b1;
          state_nxt = DIV_IDLE;
        end
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  // Operand load and one restoring step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      low      <= '0;
      dvs      <= '0;
      step     <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        rem      <= {1'b0, dividend[CNT_W+DUTY_W-1:DUTY_W]};
        low      <= dividend[DUTY_W-1:0];
        dvs      <= divisor;
        step     <= '0;
        quotient <= '0;
      end else if (iterate) begin
        rem      <= fits ? (shifted - {1'b0, dvs}) : shifted;
        quotient <= {quotient[DUTY_W-1:0], fits};
        step     <= step + STEP_W'(1);
        if (step != '0) low <= {low[DUTY_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// in clk cycles, flags a stall when no rising edge arrives before the
// period counter saturates, and optionally estimates the 8-bit duty cycle.
// Define PWM_CAPTURE_DUTY_EN to build the duty divider; without it
// duty_cycle reads 0 and duty_valid never asserts.
// SYNC_STAGES must be 2 or 3.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic              meas_valid,
  output logic              stalled,
  output logic              level,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   rise_c;
  logic                   rise_p0;
  logic                   lvl_p0;
  cap_state_t             state, state_nxt;
  logic                   cnt_start, cnt_run, do_latch, do_timeout;
  logic [CNT_W-1:0]       period_cnt, high_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~sync_prev;

  // Synchronizer chain plus edge-detect history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      sync_prev <= level;
    end
  end

  // Stage p0: registered rise/level feeding the measurement FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_p0 <= 1'b0;
      lvl_p0  <= 1'b0;
    end else begin
      rise_p0 <= rise_c;
      lvl_p0  <= level;
    end
  end

  // Measurement FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ACQUIRE;
    else     state <= state_nxt;
  end

  // Next state and counter control; a rise always beats a timeout
  always_comb begin
    state_nxt  = state;
    cnt_start  = 1'b0;
    cnt_run    = 1'b0;
    do_latch   = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ACQUIRE: begin
        if (rise_p0) begin
          cnt_start = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_p0) begin
          do_latch  = 1'b1;
          cnt_start = 1'b1;
        end else if (period_cnt == CNT_MAX) begin
          do_timeout = 1'b1;
          state_nxt  = ACQUIRE;
        end else begin
          cnt_run = 1'b1;
        end
      end
      default: state_nxt = ACQUIRE;
    endcase
  end

  // Period / high-time counters; the rise cycle itself counts as 1
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (cnt_start) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else if (cnt_run) begin
      period_cnt <= sat_inc(period_cnt);
      if (lvl_p0) high_cnt <= sat_inc(high_cnt);
    end else begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end
  end

  // Stage p1: measurement outputs, stall flag and valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      meas_valid <= do_latch | do_timeout;
      if (do_latch) begin
        period_out <= period_cnt;
        high_out   <= high_cnt;
        stalled    <= 1'b0;
      end else if (do_timeout) begin
        period_out <= '0;
        high_out   <= lvl_p0 ? CNT_MAX : '0;
        stalled    <= 1'b1;
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  logic              div_busy;
  logic              div_done;
  logic [DUTY_W:0]   div_q;

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W:0] q);
    return q[DUTY_W] ? '1 : q[DUTY_W-1:0];
  endfunction

  // Measurements that arrive while a division is running are not divided
  pwm_duty_div #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (do_latch & ~div_busy),
    .dividend ({high_cnt, {DUTY_W{1'b0}}}),
    .divisor  (period_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Duty result register: timeout forces full/empty, else divider result
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_cycle <= '0;
      duty_valid <= 1'b0;
    end else if (do_timeout) begin
      duty_cycle <= lvl_p0 ? '1 : '0;
      duty_valid <= 1'b1;
    end else if (div_done) begin
      duty_cycle <= sat_duty(div_q);
      duty_valid <= 1'b1;
    end else begin
      duty_valid <= 1'b0;
    end
  end
`else
  assign duty_cycle = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=16, SYNC_STAGES=2). Duty
// expectations follow whether PWM_CAPTURE_DUTY_EN is defined for the build.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_DUTY_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [15:0] period_out;
  logic [15:0] high_out;
  logic        meas_valid;
  logic        stalled;
  logic        level;
  logic [7:0]  duty_cycle;
  logic        duty_valid;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int n_meas = 0;
  int n_duty = 0;
  int last_meas = 0;
  int gap = 0;

  pwm_capture #(
    .CNT_W      (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .stalled   (stalled),
    .level     (level),
    .duty_cycle(duty_cycle),
    .duty_valid(duty_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dx(input logic [31:0] v);
    return DUTY_ON ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (meas_valid === 1'b1) begin
      n_meas++;
      gap = cycle - last_meas;
      last_meas = cycle;
    end
    if (duty_valid === 1'b1) n_duty++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      pwm_in = 1'b1;
      repeat (hi) cyc();
      pwm_in = 1'b0;
      repeat (lo) cyc();
    end
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    idle(3);
    chk("rst_period", 32'(period_out), 0);
    chk("rst_high", 32'(high_out), 0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_stalled", 32'(stalled), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_duty", 32'(duty_cycle), 0);
    chk("rst_duty_valid", 32'(duty_valid), 0);
    rst = 1'b0;

    // Constant low never produces a measurement
    idle(200);
    chk("low_no_meas", 32'(n_meas), 0);
    chk("low_stalled", 32'(stalled), 0);

    // 10 high / 30 low square wave, with edge-exact latency on the second rise
    n_meas = 0; n_duty = 0;
    run_wave(10, 30, 1);
    pwm_in = 1'b1;
    idle(3);
    chk("lat_before", 32'(meas_valid), 0);
    idle(1);
    chk("lat_at", 32'(meas_valid), 1);
    chk("lat_period", 32'(period_out), 40);
    chk("lat_high", 32'(high_out), 10);
    idle(6);
    pwm_in = 1'b0;
    idle(30);
    run_wave(10, 30, 4);
    chk("sq_meas_count", 32'(n_meas), 5);
    chk("sq_gap", 32'(gap), 40);
    chk("sq_period", 32'(period_out), 40);
    chk("sq_high", 32'(high_out), 10);
    chk("sq_duty", 32'(duty_cycle), dx(64));
    chk("sq_duty_count", 32'(n_duty), dx(5));

    // Generator output at duty 128: 128 high / 128 low
    run_wave(128, 128, 3);
    chk("gen_period", 32'(period_out), 256);
    chk("gen_high", 32'(high_out), 128);
    chk("gen_duty", 32'(duty_cycle), dx(128));

    // Reset 15 cycles into a 100-cycle period (10 high / 90 low)
    pwm_in = 1'b1;
    idle(10);
    pwm_in = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_period", 32'(period_out), 0);
    chk("mid_rst_high", 32'(high_out), 0);
    chk("mid_rst_meas_valid", 32'(meas_valid), 0);
    chk("mid_rst_duty", 32'(duty_cycle), 0);
    n_meas = 0; n_duty = 0;
    idle(84);
    chk("post_rst_no_meas", 32'(n_meas), 0);
    run_wave(10, 90, 1);
    chk("post_rst_one_rise", 32'(n_meas), 0);
    chk("post_rst_period0", 32'(period_out), 0);
    run_wave(10, 90, 1);
    chk("post_rst_two_rises", 32'(n_meas), 1);
    chk("post_rst_period", 32'(period_out), 100);
    chk("post_rst_high", 32'(high_out), 10);
    chk("post_rst_duty", 32'(duty_cycle), dx(25));

    // 4-cycle period (1 high / 3 low) keeps the divider busy
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    n_meas = 0; n_duty = 0;
    run_wave(1, 3, 13);
    idle(30);
    chk("fast_meas_count", 32'(n_meas), 12);
    chk("fast_gap", 32'(gap), 4);
    chk("fast_duty_count", 32'(n_duty), dx(4));
    chk("fast_period", 32'(period_out), 4);
    chk("fast_high", 32'(high_out), 1);
    chk("fast_duty", 32'(duty_cycle), dx(64));

    // Held high past counter saturation, then a 20-cycle period recovers
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    n_meas = 0; n_duty = 0;
    pwm_in = 1'b1;
    idle(70000);
    chk("to_stalled", 32'(stalled), 1);
    chk("to_period", 32'(period_out), 0);
    chk("to_high", 32'(high_out), 32'h0000_FFFF);
    chk("to_duty", 32'(duty_cycle), dx(255));
    chk("to_meas_count", 32'(n_meas), 1);
    chk("to_duty_count", 32'(n_duty), dx(1));
    chk("to_level", 32'(level), 1);
    pwm_in = 1'b0;
    idle(10);
    run_wave(10, 10, 1);
    chk("rec_still_stalled", 32'(stalled), 1);
    chk("rec_meas_count1", 32'(n_meas), 1);
    run_wave(10, 10, 1);
    chk("rec_stalled", 32'(stalled), 0);
    chk("rec_period", 32'(period_out), 20);
    chk("rec_high", 32'(high_out), 10);
    chk("rec_duty", 32'(duty_cycle), dx(128));
    chk("rec_meas_count2", 32'(n_meas), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
